ram_seq_master: RTL and testbench

- Initiator-side sequencer that drives the 16x8 synchronous single-port RAM: we, addr, data_in out; registered data_out back in.
- Accepts single or burst commands on a valid/ready host port and performs single read, single write, burst fill and burst dump.
- Returns read beats on a response port.
- Sits between a host (test sequencer, CPU glue) and the RAM instance, and hides its one-cycle read latency.

---
 rtl/ram_seq_master.sv | 159 +++++++++++++++
 tb/tb_ram_seq_master.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/ram_seq_master.sv
// Host-side sequencer for a 16x8 synchronous single-port RAM.
// Runs single/burst reads and writes and returns read beats with the RAM latency hidden.
module ram_seq_master #(
  parameter int AW = 4,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [1:0]    cmd_op,
  input  logic [AW-1:0] cmd_addr,
  input  logic [AW-1:0] cmd_len,
  input  logic [DW-1:0] cmd_data,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          rsp_valid,
  output logic [DW-1:0] rsp_data,
  output logic [AW-1:0] rsp_addr,
  output logic          rsp_last,
  output logic          done
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WR      = 2'd1,
    RD      = 2'd2,
    RD_LAST = 2'd3
  } state_t;

  state_t        r_state;
  logic [AW-1:0] r_len;
  logic [AW-1:0] r_cnt;
  logic          r_memWe;
  logic [AW-1:0] r_memAddr;
  logic [DW-1:0] r_wdata;
  logic          r_rspValid;
  logic [AW-1:0] r_rspAddr;
  logic          r_rspLast;
  logic          r_done;

  state_t        w_stateNext;
  logic [AW-1:0] w_lenNext;
  logic [AW-1:0] w_cntNext;
  logic          w_memWeNext;
  logic [AW-1:0] w_memAddrNext;
  logic [DW-1:0] w_wdataNext;
  logic          w_rspValidNext;
  logic [AW-1:0] w_rspAddrNext;
  logic          w_rspLastNext;
  logic          w_doneNext;

  logic w_accept;
  logic w_isWrite;
  logic w_isBurst;
  logic w_lastBeat;

  // Ops 01 (write) and 10 (fill) store; bit 1 selects the burst forms.
  assign w_accept   = cmd_valid && (r_state == IDLE);
  assign w_isWrite  = cmd_op[1] ^ cmd_op[0];
  assign w_isBurst  = cmd_op[1];
  assign w_lastBeat = (r_cnt == r_len);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_len      <= '0;
      r_cnt      <= '0;
      r_memWe    <= 1'b0;
      r_memAddr  <= '0;
      r_wdata    <= '0;
      r_rspValid <= 1'b0;
      r_rspAddr  <= '0;
      r_rspLast  <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_stateNext;
      r_len      <= w_lenNext;
      r_cnt      <= w_cntNext;
      r_memWe    <= w_memWeNext;
      r_memAddr  <= w_memAddrNext;
      r_wdata    <= w_wdataNext;
      r_rspValid <= w_rspValidNext;
      r_rspAddr  <= w_rspAddrNext;
      r_rspLast  <= w_rspLastNext;
      r_done     <= w_doneNext;
    end
  end

  always_comb begin
    w_stateNext    = r_state;
    w_lenNext      = r_len;
    w_cntNext      = r_cnt;
    w_memWeNext    = r_memWe;
    w_memAddrNext  = r_memAddr;
    w_wdataNext    = r_wdata;
    w_rspValidNext = 1'b0;
    w_rspAddrNext  = r_rspAddr;
    w_rspLastNext  = 1'b0;
    w_doneNext     = 1'b0;

    case (r_state)
      IDLE: begin
        w_memWeNext = 1'b0;
        if (w_accept) begin
          w_lenNext     = w_isBurst ? cmd_len : '0;
          w_cntNext     = '0;
          w_memAddrNext = cmd_addr;
          w_memWeNext   = w_isWrite;
          w_wdataNext   = cmd_data;
          w_stateNext   = w_isWrite ? WR : RD;
        end
      end
      WR: begin
        if (w_lastBeat) begin
          w_memWeNext = 1'b0;
          w_doneNext  = 1'b0 | 1'b1;
          w_stateNext = IDLE;
        end else begin
          w_cntNext     = r_cnt + AW'(1);
          w_memAddrNext = r_memAddr + AW'(1);
        end
      end
      RD: begin
        // The RAM returns data for the address presented last cycle, so each beat trails its address by one edge.
        w_rspValidNext = 1'b1;
        w_rspAddrNext  = r_memAddr;
        if (w_lastBeat) begin
          w_rspLastNext = 1'b1;
          w_stateNext   = RD_LAST;
        end else begin
          w_cntNext     = r_cnt + AW'(1);
          w_memAddrNext = r_memAddr + AW'(1);
        end
      end
      RD_LAST: begin
        w_doneNext  = 1'b1;
        w_stateNext = IDLE;
      end
      default: begin
        w_stateNext = IDLE;
        w_memWeNext = 1'b0;
      end
    endcase
  end

  assign cmd_ready = (r_state == IDLE);
  assign mem_we    = r_memWe;
  assign mem_addr  = r_memAddr;
  assign mem_wdata = r_wdata;
  assign rsp_valid = r_rspValid;
  assign rsp_data  = mem_rdata;
  assign rsp_addr  = r_rspAddr;
  assign rsp_last  = r_rspLast;
  assign done      = r_done;

endmodule

// File: tb/tb_ram_seq_master.sv
// Self-checking bench for ram_seq_master: behavioural RAM plus scoreboards
// for RAM writes, read beats and done pulses, each tagged with its expected cycle.
module tb_ram_seq_master;

  localparam int AW = 4;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [1:0]    cmd_op = 2'd0;
  logic [AW-1:0] cmd_addr = '0;
  logic [AW-1:0] cmd_len = '0;
  logic [DW-1:0] cmd_data = '0;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          rsp_valid;
  logic [DW-1:0] rsp_data;
  logic [AW-1:0] rsp_addr;
  logic          rsp_last;
  logic          done;

  ram_seq_master #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_data(cmd_data),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_addr(rsp_addr),
    .rsp_last(rsp_last), .done(done)
  );

  always #5 clk = ~clk;

  // Behavioural 16x8 synchronous RAM with registered read data.
  logic [DW-1:0] ram [16];
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  int cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          last;
    int            cyc;
  } beat_t;

  beat_t rspQ[$];
  beat_t wrQ[$];
  int    doneQ[$];
  logic [DW-1:0] model [16];

  int checks = 0;
  int failures = 0;

  task automatic checkOutput(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cycle);
    end
  endtask

  // Scoreboard monitor: every observed write, beat and done must match the head of its queue.
  beat_t monB;
  int    monD;
  always @(negedge clk) begin
    if (!rst) begin
      if (mem_we === 1'b1) begin
        if (wrQ.size() == 0) checkOutput("wr_extra", 1, 0);
        else begin
          monB = wrQ.pop_front();
          checkOutput("wr_addr", int'(mem_addr), int'(monB.addr));
          checkOutput("wr_data", int'(mem_wdata), int'(monB.data));
          checkOutput("wr_cycle", cycle, monB.cyc);
        end
      end
      if (rsp_valid === 1'b1) begin
        if (rspQ.size() == 0) checkOutput("rsp_extra", 1, 0);
        else begin
          monB = rspQ.pop_front();
          checkOutput("rsp_data", int'(rsp_data), int'(monB.data));
          checkOutput("rsp_addr", int'(rsp_addr), int'(monB.addr));
          checkOutput("rsp_last", int'(rsp_last), int'(monB.last));
          checkOutput("rsp_cycle", cycle, monB.cyc);
        end
      end
      if (done === 1'b1) begin
        if (doneQ.size() == 0) checkOutput("done_extra", 1, 0);
        else begin
          monD = doneQ.pop_front();
          checkOutput("done_cycle", cycle, monD);
        end
      end
    end
  end

  // Presents a command, holds it until accepted, then queues the expected results.
  task automatic applyStimulus(input logic [1:0] op, input logic [AW-1:0] addr,
                               input logic [AW-1:0] len, input logic [DW-1:0] data,
                               output int acceptCycle);
    int n;
    int waitCnt;
    logic [AW-1:0] a;
    @(negedge clk);
    cmd_op = op; cmd_addr = addr; cmd_len = len; cmd_data = data; cmd_valid = 1'b1;
    waitCnt = 0;
    while (cmd_ready !== 1'b1 && waitCnt < 200) begin
      @(negedge clk);
      waitCnt++;
    end
    if (waitCnt >= 200) begin
      checkOutput("accept_timeout", 1, 0);
      cmd_valid = 1'b0;
      acceptCycle = -1;
      return;
    end
    @(posedge clk);
    #1;
    acceptCycle = cycle;
    cmd_valid = 1'b0;
    n = op[1] ? int'(len) : 0;
    for (int k = 0; k <= n; k++) begin
      a = addr + AW'(k);
      if (op == 2'b01 || op == 2'b10) begin
        wrQ.push_back('{a, data, (k == n), acceptCycle + k});
        model[a] = data;
      end else begin
        rspQ.push_back('{a, model[a], (k == n), acceptCycle + k + 1});
      end
    end
    if (op == 2'b01 || op == 2'b10) doneQ.push_back(acceptCycle + n + 1);
    else doneQ.push_back(acceptCycle + n + 2);
  endtask

  task automatic waitIdle();
    int waitCnt = 0;
    while ((rspQ.size() != 0 || wrQ.size() != 0 || doneQ.size() != 0) && waitCnt < 200) begin
      @(negedge clk);
      waitCnt++;
    end
    if (waitCnt >= 200) checkOutput("idle_timeout", 1, 0);
    @(negedge clk);
  endtask

  int c0;
  int c1;
  int doneSeen;

  initial begin
    $display("[TB] start");
    // 1: asynchronous reset asserted mid-cycle
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checkOutput("rst_cmd_ready", int'(cmd_ready), 1);
    checkOutput("rst_mem_we", int'(mem_we), 0);
    checkOutput("rst_rsp_valid", int'(rsp_valid), 0);
    checkOutput("rst_done", int'(done), 0);
    checkOutput("rst_mem_addr", int'(mem_addr), 0);
    checkOutput("rst_rsp_addr", int'(rsp_addr), 0);
    checkOutput("rst_rsp_last", int'(rsp_last), 0);
    @(negedge clk);
    rst = 1'b0;

    // 2: single write then single read
    applyStimulus(2'b01, 4'd3, 4'd9, 8'hA5, c0);
    waitIdle();
    applyStimulus(2'b00, 4'd3, 4'd7, 8'h00, c0);
    waitIdle();

    // 3: wrapping fill and dump
    applyStimulus(2'b10, 4'd14, 4'd3, 8'h3C, c0);
    waitIdle();
    applyStimulus(2'b11, 4'd14, 4'd3, 8'h00, c0);
    waitIdle();

    // 4: distinct data everywhere, then full-depth dump
    for (int a = 0; a < 16; a++) begin
      applyStimulus(2'b01, AW'(a), 4'd0, DW'(a) ^ 8'hFF, c0);
      waitIdle();
    end
    applyStimulus(2'b11, 4'd0, 4'd15, 8'h00, c0);
    waitIdle();

    // 5: reset aborts a fill after two writes
    applyStimulus(2'b10, 4'd0, 4'd7, 8'h55, c0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    checkOutput("abort_mem_we", int'(mem_we), 0);
    checkOutput("abort_done", int'(done), 0);
    checkOutput("abort_cmd_ready", int'(cmd_ready), 1);
    checkOutput("abort_pending_wr", wrQ.size(), 6);
    checkOutput("abort_pending_done", doneQ.size(), 1);
    wrQ.delete();
    doneQ.delete();
    for (int a = 2; a < 8; a++) model[a] = DW'(a) ^ 8'hFF;
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    applyStimulus(2'b11, 4'd0, 4'd3, 8'h00, c0);
    waitIdle();

    // 6: second command held during a dump is taken on the edge ending done
    applyStimulus(2'b11, 4'd0, 4'd3, 8'h00, c0);
    doneSeen = doneQ.size();
    applyStimulus(2'b00, 4'd5, 4'd0, 8'h00, c1);
    checkOutput("b2b_accept_cycle", c1, c0 + 6);
    checkOutput("b2b_mem_addr", int'(mem_addr), 5);
    checkOutput("b2b_mem_we", int'(mem_we), 0);
    checkOutput("b2b_first_done_pending", doneSeen, 1);
    waitIdle();

    checkOutput("end_rspQ", rspQ.size(), 0);
    checkOutput("end_wrQ", wrQ.size(), 0);
    checkOutput("end_doneQ", doneQ.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
